// File: rtl/tpu_fetch_decode.sv
// tpu_fetch_decode: instruction fetch/decode front end of the TPU controller.
// Fetches from a synchronous-read imem, keeps one spare fetch buffer entry,
// holds the current instruction in ir until its target unit is free, and
// dispatches it on the registered exec_* bundle.
module tpu_fetch_decode #(
  parameter int unsigned             PC_WIDTH     = 8,
  parameter int unsigned             OPCODE_WIDTH = 6,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 6'h3F
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [PC_WIDTH-1:0]     start_pc,
  output logic                    imem_rd_en,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [31:0]             imem_rdata,
  input  logic                    sys_busy,
  input  logic                    vpu_busy,
  input  logic                    dma_busy,
  input  logic                    wt_fifo_full,
  output logic                    exec_valid,
  output logic [OPCODE_WIDTH-1:0] exec_opcode,
  output logic [7:0]              exec_arg1,
  output logic [7:0]              exec_arg2,
  output logic [7:0]              exec_arg3,
  output logic [1:0]              exec_flags,
  output logic [PC_WIDTH-1:0]     exec_pc,
  output logic                    pipeline_stall,
  output logic [1:0]              current_stage,
  output logic                    halted,
  output logic [PC_WIDTH-1:0]     halt_pc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b11
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_MATMUL    = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_RD_WEIGHT = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_RELU      = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SYNC      = OPCODE_WIDTH'(4);

  state_e                    state_q;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic                      fetch_pending_q, fetch_pending_d;
  logic [PC_WIDTH-1:0]       fetch_pc_q, fetch_pc_d;
  logic                      fb_valid_q, fb_valid_d;
  logic [31:0]               fb_data_q, fb_data_d;
  logic [PC_WIDTH-1:0]       fb_pc_q, fb_pc_d;
  logic                      ir_valid_q, ir_valid_d;
  logic [31:0]               ir_data_q, ir_data_d;
  logic [PC_WIDTH-1:0]       ir_pc_q, ir_pc_d;
  logic                      exec_valid_q, exec_valid_d;
  logic [OPCODE_WIDTH-1:0]   exec_opcode_q, exec_opcode_d;
  logic [1:0]                exec_flags_q, exec_flags_d;
  logic [7:0]                exec_arg1_q, exec_arg1_d;
  logic [7:0]                exec_arg2_q, exec_arg2_d;
  logic [7:0]                exec_arg3_q, exec_arg3_d;
  logic [PC_WIDTH-1:0]       exec_pc_q, exec_pc_d;
  logic [PC_WIDTH-1:0]       halt_pc_q, halt_pc_d;

  logic [OPCODE_WIDTH-1:0]   ir_op;
  logic                      any_busy;
  logic                      hazard;
  logic                      advance;
  logic                      halt_adv;
  logic                      start_ok;

  // Hazard check on the instruction in ir, including the same-unit scoreboard
  // that covers the one-cycle lag before the unit raises its busy flag.
  always_comb begin
    ir_op    = ir_data_q[31 -: OPCODE_WIDTH];
    any_busy = sys_busy | vpu_busy | dma_busy;
    hazard   = 1'b0;
    case (ir_op)
      OP_MATMUL:    hazard = sys_busy | (exec_valid_q & (exec_opcode_q == OP_MATMUL));
      OP_RD_WEIGHT: hazard = wt_fifo_full;
      OP_RELU:      hazard = vpu_busy | (exec_valid_q & (exec_opcode_q == OP_RELU));
      OP_SYNC:      hazard = any_busy;
      default:      hazard = (ir_op == HALT_OPCODE) & any_busy;
    endcase
    pipeline_stall = ir_valid_q & hazard;
    advance        = ir_valid_q & ~hazard;
    halt_adv       = advance & (ir_op == HALT_OPCODE);
    start_ok       = start & (state_q != S_RUN);
    imem_rd_en     = (state_q == S_RUN) & ~fb_valid_q & ~pipeline_stall;
  end

  // Next-state for PC, fetch tracking, fetch buffer, ir and the exec bundle.
  always_comb begin
    pc_d            = pc_q;
    fetch_pending_d = imem_rd_en;
    fetch_pc_d      = imem_rd_en ? pc_q : fetch_pc_q;
    fb_valid_d      = fb_valid_q;
    fb_data_d       = fb_data_q;
    fb_pc_d         = fb_pc_q;
    ir_valid_d      = ir_valid_q;
    ir_data_d       = ir_data_q;
    ir_pc_d         = ir_pc_q;
    exec_valid_d    = advance & ~halt_adv;
    exec_opcode_d   = exec_opcode_q;
    exec_flags_d    = exec_flags_q;
    exec_arg1_d     = exec_arg1_q;
    exec_arg2_d     = exec_arg2_q;
    exec_arg3_d     = exec_arg3_q;
    exec_pc_d       = exec_pc_q;
    halt_pc_d       = halt_pc_q;

    if (start_ok) begin
      pc_d = start_pc;
    end else if (imem_rd_en) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end

    // ir takes from fb first; returning data then backfills fb so order holds.
    if (!ir_valid_q || advance) begin
      if (fb_valid_q) begin
        ir_valid_d = 1'b1;
        ir_data_d  = fb_data_q;
        ir_pc_d    = fb_pc_q;
        fb_valid_d = fetch_pending_q;
        if (fetch_pending_q) begin
          fb_data_d = imem_rdata;
          fb_pc_d   = fetch_pc_q;
        end
      end else if (fetch_pending_q) begin
        ir_valid_d = 1'b1;
        ir_data_d  = imem_rdata;
        ir_pc_d    = fetch_pc_q;
      end else begin
        ir_valid_d = 1'b0;
      end
    end else if (fetch_pending_q) begin
      fb_valid_d = 1'b1;
      fb_data_d  = imem_rdata;
      fb_pc_d    = fetch_pc_q;
    end

    if (exec_valid_d) begin
      exec_opcode_d = ir_op;
      exec_flags_d  = ir_data_q[25:24];
      exec_arg1_d   = ir_data_q[23:16];
      exec_arg2_d   = ir_data_q[15:8];
      exec_arg3_d   = ir_data_q[7:0];
      exec_pc_d     = ir_pc_q;
    end

    if (halt_adv) begin
      halt_pc_d       = ir_pc_q;
      ir_valid_d      = 1'b0;
      fb_valid_d      = 1'b0;
      fetch_pending_d = 1'b0;
    end
  end

  // Control FSM and all pipeline registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      fetch_pending_q <= 1'b0;
      fetch_pc_q      <= '0;
      fb_valid_q      <= 1'b0;
      fb_data_q       <= '0;
      fb_pc_q         <= '0;
      ir_valid_q      <= 1'b0;
      ir_data_q       <= '0;
      ir_pc_q         <= '0;
      exec_valid_q    <= 1'b0;
      exec_opcode_q   <= '0;
      exec_flags_q    <= '0;
      exec_arg1_q     <= '0;
      exec_arg2_q     <= '0;
      exec_arg3_q     <= '0;
      exec_pc_q       <= '0;
      halt_pc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: if (start) state_q <= S_RUN;
        S_RUN:            if (halt_adv) state_q <= S_HALTED;
        default:          state_q <= S_IDLE;
      endcase
      pc_q            <= pc_d;
      fetch_pending_q <= fetch_pending_d;
      fetch_pc_q      <= fetch_pc_d;
      fb_valid_q      <= fb_valid_d;
      fb_data_q       <= fb_data_d;
      fb_pc_q         <= fb_pc_d;
      ir_valid_q      <= ir_valid_d;
      ir_data_q       <= ir_data_d;
      ir_pc_q         <= ir_pc_d;
      exec_valid_q    <= exec_valid_d;
      exec_opcode_q   <= exec_opcode_d;
      exec_flags_q    <= exec_flags_d;
      exec_arg1_q     <= exec_arg1_d;
      exec_arg2_q     <= exec_arg2_d;
      exec_arg3_q     <= exec_arg3_d;
      exec_pc_q       <= exec_pc_d;
      halt_pc_q       <= halt_pc_d;
    end
  end

  // Stage encoding seen by the controller status register.
  always_comb begin
    case (state_q)
      S_RUN:    current_stage = pipeline_stall ? 2'b10 : 2'b01;
      S_HALTED: current_stage = 2'b11;
      default:  current_stage = 2'b00;
    endcase
  end

  assign imem_addr   = pc_q;
  assign exec_valid  = exec_valid_q;
  assign exec_opcode = exec_opcode_q;
  assign exec_flags  = exec_flags_q;
  assign exec_arg1   = exec_arg1_q;
  assign exec_arg2   = exec_arg2_q;
  assign exec_arg3   = exec_arg3_q;
  assign exec_pc     = exec_pc_q;
  assign halt_pc     = halt_pc_q;
  assign halted      = (state_q == S_HALTED);

endmodule
